trap_controller: RTL and testbench

//  Machine-mode trap sequencer; subscriber side of exception_if.

---
 rtl/trap_controller_pkg.sv | 47 ++++
 rtl/exception_if.sv | 22 ++
 rtl/trap_controller_cause_encoder.sv | 43 ++++
 rtl/trap_controller.sv | 169 ++++++++++++++++
 tb/tb_trap_controller.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_controller_pkg.sv
// Shared types and CSR addresses for the machine-mode trap sequencer.
// Exception event structs are grouped by the pipeline stage that raises them.
package trap_controller_pkg;

    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [11:0] MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        CAUSE_INST_MISALIGNED  = 4'd0,
        CAUSE_INST_FAULT       = 4'd1,
        CAUSE_ILLEGAL          = 4'd2,
        CAUSE_BREAKPOINT       = 4'd3,
        CAUSE_LOAD_MISALIGNED  = 4'd4,
        CAUSE_LOAD_FAULT       = 4'd5,
        CAUSE_STORE_MISALIGNED = 4'd6,
        CAUSE_STORE_FAULT      = 4'd7,
        CAUSE_ECALL_M          = 4'd11
    } trap_cause_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        MRET = 2'd2
    } trap_state_e;

    typedef struct packed {
        logic misaligned;
        logic fault;
    } inst_fetch_exception_t;

    typedef struct packed {
        logic illegal;
        logic ecall;
        logic ebreak;
    } decoder_exception_t;

    typedef struct packed {
        logic load_misaligned;
        logic load_fault;
        logic store_misaligned;
        logic store_fault;
    } ldst_exception_t;

endpackage

// File: rtl/exception_if.sv
// Exception event bundle between the pipeline (publisher) and the trap sequencer (subscriber).
interface exception_if;
    import trap_controller_pkg::*;

    inst_fetch_exception_t fetch;
    decoder_exception_t    dec;
    ldst_exception_t       ldst;
    logic [31:0]           current_pc;
    logic [31:0]           epc_value;
    logic [31:0]           trap_handler_addr;
    logic                  trap_enable;

    modport subscriber (
        input  fetch, dec, ldst, current_pc,
        output epc_value, trap_handler_addr, trap_enable
    );

    modport publisher (
        output fetch, dec, ldst, current_pc,
        input  epc_value, trap_handler_addr, trap_enable
    );
endinterface

// File: rtl/trap_controller_cause_encoder.sv
// Combinational priority encoder: picks the single architecturally visible cause
// among all simultaneously flagged exceptions of the current instruction.
module trap_cause_encoder
    import trap_controller_pkg::*;
(
    input  inst_fetch_exception_t fetch,
    input  decoder_exception_t    dec,
    input  ldst_exception_t       ldst,
    output logic                  valid,
    output trap_cause_e           cause,
    output logic                  tval_zero
);

    always_comb begin
        valid     = 1'b1;
        cause     = CAUSE_INST_MISALIGNED;
        tval_zero = 1'b0;
        if (fetch.misaligned) begin
            cause = CAUSE_INST_MISALIGNED;
        end else if (fetch.fault) begin
            cause = CAUSE_INST_FAULT;
        end else if (dec.ebreak) begin
            cause     = CAUSE_BREAKPOINT;
            tval_zero = 1'b1;
        end else if (dec.ecall) begin
            cause     = CAUSE_ECALL_M;
            tval_zero = 1'b1;
        end else if (dec.illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (ldst.load_misaligned) begin
            cause = CAUSE_LOAD_MISALIGNED;
        end else if (ldst.load_fault) begin
            cause = CAUSE_LOAD_FAULT;
        end else if (ldst.store_misaligned) begin
            cause = CAUSE_STORE_MISALIGNED;
        end else if (ldst.store_fault) begin
            cause = CAUSE_STORE_FAULT;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: owns the trap CSRs, redirects fetch on trap/mret
// and holds the redirect until the pipeline reports the flush complete.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter int          FLUSH_MAX   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    exception_if.subscriber exc,
    input  logic [31:0] fault_value,
    input  logic        mret_valid,
    input  logic        flush_done,
    input  logic [11:0] csr_addr,
    input  logic        csr_wen,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        ret_enable,
    output logic [31:0] ret_addr,
    output logic        trap_fatal
);

    localparam int WDOG_W = (FLUSH_MAX > 2) ? $clog2(FLUSH_MAX) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(FLUSH_MAX - 1);

    trap_state_e       state_q, state_d;
    logic [31:0]       mtvec_q, mtvec_d;
    logic [31:0]       mepc_q, mepc_d;
    logic [31:0]       mtval_q, mtval_d;
    logic              mcause_int_q, mcause_int_d;
    logic [3:0]        mcause_code_q, mcause_code_d;
    logic              mie_q, mie_d;
    logic              mpie_q, mpie_d;
    logic              trap_en_q, trap_en_d;
    logic              ret_en_q, ret_en_d;
    logic              fatal_q, fatal_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic        enc_valid;
    trap_cause_e enc_cause;
    logic        enc_tval_zero;

    trap_cause_encoder u_cause_encoder (
        .fetch     (exc.fetch),
        .dec       (exc.dec),
        .ldst      (exc.ldst),
        .valid     (enc_valid),
        .cause     (enc_cause),
        .tval_zero (enc_tval_zero)
    );

    always_comb begin
        csr_rdata = 32'h0;
        csr_hit   = 1'b1;
        case (csr_addr)
            MSTATUS: csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            MTVEC:   csr_rdata = mtvec_q;
            MEPC:    csr_rdata = mepc_q;
            MCAUSE:  csr_rdata = {mcause_int_q, 27'h0, mcause_code_q};
            MTVAL:   csr_rdata = mtval_q;
            default: csr_hit   = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mtval_d       = mtval_q;
        mcause_int_d  = mcause_int_q;
        mcause_code_d = mcause_code_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        fatal_d       = fatal_q;
        wdog_d        = wdog_q;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                // Arbitration order: exception, then mret, then CSR write.
                if (enc_valid) begin
                    state_d       = TRAP;
                    mepc_d        = exc.current_pc & ~32'h3;
                    mcause_int_d  = 1'b0;
                    mcause_code_d = enc_cause;
                    mtval_d       = enc_tval_zero ? 32'h0 : fault_value;
                    mpie_d        = mie_q;
                    mie_d         = 1'b0;
                end else if (mret_valid) begin
                    state_d = MRET;
                    mie_d   = mpie_q;
                    mpie_d  = 1'b1;
                end else if (csr_wen && csr_hit) begin
                    case (csr_addr)
                        MSTATUS: begin
                            mie_d  = csr_wdata[3];
                            mpie_d = csr_wdata[7];
                        end
                        MTVEC:   mtvec_d = csr_wdata & ~32'h3;
                        MEPC:    mepc_d  = csr_wdata & ~32'h3;
                        MCAUSE: begin
                            mcause_int_d  = csr_wdata[31];
                            mcause_code_d = csr_wdata[3:0];
                        end
                        MTVAL:   mtval_d = csr_wdata;
                        default: ;
                    endcase
                end
            end
            TRAP, MRET: begin
                if (flush_done) begin
                    state_d = IDLE;
                    wdog_d  = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = IDLE;
                    fatal_d = 1'b1;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect strobes are decoded from the next state so they are flop outputs.
        trap_en_d = (state_d == TRAP);
        ret_en_d  = (state_d == MRET);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            mtvec_q       <= MTVEC_RESET;
            mepc_q        <= 32'h0;
            mtval_q       <= 32'h0;
            mcause_int_q  <= 1'b0;
            mcause_code_q <= 4'h0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            trap_en_q     <= 1'b0;
            ret_en_q      <= 1'b0;
            fatal_q       <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mtval_q       <= mtval_d;
            mcause_int_q  <= mcause_int_d;
            mcause_code_q <= mcause_code_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            trap_en_q     <= trap_en_d;
            ret_en_q      <= ret_en_d;
            fatal_q       <= fatal_d;
            wdog_q        <= wdog_d;
        end
    end

    assign exc.trap_enable       = trap_en_q;
    assign exc.epc_value         = mepc_q;
    assign exc.trap_handler_addr = mtvec_q & ~32'h3;
    assign ret_enable            = ret_en_q;
    assign ret_addr              = mepc_q;
    assign trap_fatal            = fatal_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with a cycle-level reference model and per-cycle compare.
module tb_trap_controller;
    import trap_controller_pkg::*;

    localparam int FLUSH_MAX = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] fault_value;
    logic        mret_valid;
    logic        flush_done;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        ret_enable;
    logic [31:0] ret_addr;
    logic        trap_fatal;

    exception_if exc_if ();

    trap_controller #(.MTVEC_RESET(32'h0000_0100), .FLUSH_MAX(FLUSH_MAX)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .exc         (exc_if),
        .fault_value (fault_value),
        .mret_valid  (mret_valid),
        .flush_done  (flush_done),
        .csr_addr    (csr_addr),
        .csr_wen     (csr_wen),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .ret_enable  (ret_enable),
        .ret_addr    (ret_addr),
        .trap_fatal  (trap_fatal)
    );

    always #10 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = idle, 1 = trap redirect held, 2 = mret redirect held
    int          m_mode;
    int          m_cycles;
    logic [31:0] m_mtvec, m_mepc, m_mtval;
    logic        m_int, m_mie, m_mpie, m_fatal;
    logic [3:0]  m_code;
    bit          model_valid = 0;

    function automatic logic [8:0] ev_vec();
        return {exc_if.fetch.misaligned, exc_if.fetch.fault, exc_if.dec.ebreak,
                exc_if.dec.ecall, exc_if.dec.illegal, exc_if.ldst.load_misaligned,
                exc_if.ldst.load_fault, exc_if.ldst.store_misaligned, exc_if.ldst.store_fault};
    endfunction

    always @(posedge CLK) begin
        int codes[9];
        logic [8:0] v;
        int found;
        codes = '{0, 1, 3, 11, 2, 4, 5, 6, 7};
        if (RST) begin
            m_mode = 0; m_cycles = 0; m_mtvec = 32'h100; m_mepc = 0; m_mtval = 0;
            m_int = 0; m_code = 0; m_mie = 0; m_mpie = 0; m_fatal = 0;
        end else if (m_mode == 0) begin
            v = ev_vec();
            found = -1;
            for (int i = 0; i < 9; i++)
                if (found < 0 && v[8-i]) found = codes[i];
            if (found >= 0) begin
                m_mode = 1; m_cycles = 0;
                m_mepc = {exc_if.current_pc[31:2], 2'b00};
                m_int = 0; m_code = 4'(found);
                m_mtval = (found == 3 || found == 11) ? 32'h0 : fault_value;
                m_mpie = m_mie; m_mie = 0;
            end else if (mret_valid) begin
                m_mode = 2; m_cycles = 0; m_mie = m_mpie; m_mpie = 1;
            end else if (csr_wen) begin
                if (csr_addr == MSTATUS) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                if (csr_addr == MTVEC) m_mtvec = {csr_wdata[31:2], 2'b00};
                if (csr_addr == MEPC) m_mepc = {csr_wdata[31:2], 2'b00};
                if (csr_addr == MCAUSE) begin m_int = csr_wdata[31]; m_code = csr_wdata[3:0]; end
                if (csr_addr == MTVAL) m_mtval = csr_wdata;
            end
        end else begin
            m_cycles++;
            if (flush_done) m_mode = 0;
            else if (m_cycles == FLUSH_MAX) begin m_mode = 0; m_fatal = 1; end
        end
        model_valid = 1;
    end

    function automatic logic [32:0] model_csr(input logic [11:0] a);
        case (a)
            MSTATUS: return {1'b1, 24'h0, m_mpie, 3'b000, m_mie, 3'b000};
            MTVEC:   return {1'b1, m_mtvec};
            MEPC:    return {1'b1, m_mepc};
            MCAUSE:  return {1'b1, m_int, 27'h0, m_code};
            MTVAL:   return {1'b1, m_mtval};
            default: return 33'h0;
        endcase
    endfunction

    always @(negedge CLK) begin
        logic [32:0] exp_csr;
        if (model_valid && !RST) begin
            exp_csr = model_csr(csr_addr);
            chk("trap_enable", {31'h0, exc_if.trap_enable}, {31'h0, m_mode == 1});
            chk("ret_enable",  {31'h0, ret_enable},         {31'h0, m_mode == 2});
            chk("trap_fatal",  {31'h0, trap_fatal},         {31'h0, m_fatal});
            chk("ret_addr",    ret_addr,                     m_mepc);
            chk("csr_hit",     {31'h0, csr_hit},             {31'h0, exp_csr[32]});
            chk("csr_rdata",   csr_rdata,                    exp_csr[31:0]);
            if (m_mode == 1) begin
                chk("epc_value", exc_if.epc_value,         m_mepc);
                chk("handler",   exc_if.trap_handler_addr, m_mtvec);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ev(input logic [8:0] v);
        exc_if.fetch.misaligned     = v[8];
        exc_if.fetch.fault          = v[7];
        exc_if.dec.ebreak           = v[6];
        exc_if.dec.ecall            = v[5];
        exc_if.dec.illegal          = v[4];
        exc_if.ldst.load_misaligned = v[3];
        exc_if.ldst.load_fault      = v[2];
        exc_if.ldst.store_misaligned = v[1];
        exc_if.ldst.store_fault     = v[0];
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_wen = 1'b1;
        cyc();
        csr_wen = 1'b0;
    endtask

    localparam logic [8:0] EV_ECALL = 9'h020;

    logic [8:0]  tbl_ev[7]   = '{9'h018, 9'h050, 9'h003, 9'h001, 9'h009, 9'h0A0, 9'h004};
    logic [31:0] tbl_code[7] = '{32'd2, 32'd3, 32'd6, 32'd7, 32'd4, 32'd1, 32'd5};
    bit          tbl_tz[7]   = '{0, 1, 0, 0, 0, 0, 0};

    initial begin
        int n;
        RST = 1'b1; fault_value = 0; mret_valid = 0; flush_done = 0;
        csr_addr = MTVEC; csr_wen = 0; csr_wdata = 0;
        exc_if.current_pc = 0;
        set_ev(9'h0);
        cyc(); cyc();
        RST = 1'b0;

        rd("reset_mtvec", MTVEC, 32'h0000_0100);
        chk("reset_hit", {31'h0, csr_hit}, 32'h1);
        wr(MTVEC, 32'h8000_0003);
        #1;
        rd("mtvec_aligned", MTVEC, 32'h8000_0000);
        wr(MSTATUS, 32'hFFFF_FF7F);
        #1;
        rd("mstatus_mask", MSTATUS, 32'h0000_0008);
        rd("unowned_rdata", 12'h344, 32'h0);
        chk("unowned_hit", {31'h0, csr_hit}, 32'h0);

        // ecall with a competing mepc write: the write must be dropped
        exc_if.current_pc = 32'h200; set_ev(EV_ECALL);
        csr_addr = MEPC; csr_wdata = 32'h1234; csr_wen = 1;
        cyc();
        set_ev(9'h0); csr_wen = 0;
        chk("ecall_trap_en", {31'h0, exc_if.trap_enable}, 32'h1);
        chk("ecall_handler", exc_if.trap_handler_addr, 32'h8000_0000);
        chk("ecall_epc", exc_if.epc_value, 32'h200);
        rd("ecall_mepc", MEPC, 32'h200);
        rd("ecall_mcause", MCAUSE, 32'd11);
        rd("ecall_mtval", MTVAL, 32'h0);
        rd("ecall_mstatus", MSTATUS, 32'h0000_0080);
        // events and CSR writes in TRAP are ignored
        set_ev(9'h080); csr_addr = MTVEC; csr_wdata = 32'hDEAD_0000; csr_wen = 1;
        cyc();
        set_ev(9'h0); csr_wen = 0;
        rd("trap_ign_mtvec", MTVEC, 32'h8000_0000);
        rd("trap_ign_mcause", MCAUSE, 32'd11);
        flush_done = 1;
        cyc();
        flush_done = 0;
        chk("flush_idle", {31'h0, exc_if.trap_enable}, 32'h0);

        // mret
        mret_valid = 1;
        cyc();
        mret_valid = 0;
        chk("mret_ret_en", {31'h0, ret_enable}, 32'h1);
        chk("mret_addr", ret_addr, 32'h200);
        rd("mret_mstatus", MSTATUS, 32'h0000_0088);
        cyc();
        flush_done = 1;
        cyc();
        flush_done = 0;
        chk("mret_done", {31'h0, ret_enable}, 32'h0);

        // fetch misaligned beats load fault; flush_done honoured in first trap cycle
        exc_if.current_pc = 32'h301; fault_value = 32'h1002; set_ev(9'h104);
        cyc();
        set_ev(9'h0); flush_done = 1;
        rd("fm_mcause", MCAUSE, 32'd0);
        rd("fm_mtval", MTVAL, 32'h1002);
        rd("fm_mepc", MEPC, 32'h300);
        cyc();
        flush_done = 0;
        chk("fm_min_res", {31'h0, exc_if.trap_enable}, 32'h0);

        // event beats mret
        set_ev(EV_ECALL); mret_valid = 1;
        cyc();
        set_ev(9'h0); mret_valid = 0;
        chk("evt_vs_mret", {30'h0, exc_if.trap_enable, ret_enable}, 32'h2);
        flush_done = 1; cyc(); flush_done = 0;

        // priority table
        for (int i = 0; i < 7; i++) begin
            fault_value = 32'hA000_0000 + i; exc_if.current_pc = 32'h400 + 4 * i;
            set_ev(tbl_ev[i]);
            cyc();
            set_ev(9'h0);
            rd($sformatf("prio%0d_mcause", i), MCAUSE, tbl_code[i]);
            rd($sformatf("prio%0d_mtval", i), MTVAL, tbl_tz[i] ? 32'h0 : 32'hA000_0000 + i);
            flush_done = 1; cyc(); flush_done = 0;
        end

        // watchdog expiry
        set_ev(EV_ECALL);
        cyc();
        set_ev(9'h0);
        n = 0;
        while (exc_if.trap_enable && n < 40) begin
            n++;
            cyc();
        end
        chk("wdog_cycles", n, FLUSH_MAX);
        chk("wdog_fatal", {31'h0, trap_fatal}, 32'h1);
        cyc();
        chk("wdog_sticky", {31'h0, trap_fatal}, 32'h1);
        RST = 1; cyc(); RST = 0;
        chk("rst_clr_fatal", {31'h0, trap_fatal}, 32'h0);

        // reset mid-trap
        exc_if.current_pc = 32'h500; set_ev(EV_ECALL);
        cyc();
        set_ev(9'h0);
        chk("pre_rst_trap", {31'h0, exc_if.trap_enable}, 32'h1);
        RST = 1; cyc(); RST = 0;
        chk("rst_trap_en", {31'h0, exc_if.trap_enable}, 32'h0);
        chk("rst_ret_en", {31'h0, ret_enable}, 32'h0);
        rd("rst_mtvec", MTVEC, 32'h0000_0100);
        rd("rst_mepc", MEPC, 32'h0);
        cyc();
        chk("rst_no_redirect", {30'h0, exc_if.trap_enable, ret_enable}, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
